riscv_fetch_stage: RTL and testbench
====================================

RISCV_FETCH_STAGE -- requirements
Module: riscv_fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 Parameter XLEN, default 32, SHALL set the width of all address, PC and instruction ports.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 imem_req_valid  output  1  SHALL flag a valid instruction-memory fetch request.
REQ-006 imem_req_ready  input  1  SHALL flag that memory accepts the request this cycle.
REQ-007 imem_req_addr  output  XLEN  SHALL carry the fetch byte address, word-aligned.
REQ-008 imem_rsp_valid  input  1  SHALL flag the instruction word returned for the oldest outstanding request.
REQ-009 imem_rsp_data  input  XLEN  SHALL carry the returned instruction word.
REQ-010 stall_i  input  1  SHALL flag that the decode stage does not consume the IF/ID entry this cycle.
REQ-011 redirect_valid  input  1  SHALL flag a taken branch/jump from execute.
REQ-012 redirect_pc  input  XLEN  SHALL carry the redirect target.
REQ-013 if_id_valid  output  1  SHALL flag that if_id_pc/if_id_instr hold a valid instruction.
REQ-014 if_id_pc  output  XLEN  SHALL carry the pc field of the IF/ID bundle.
REQ-015 if_id_instr  output  XLEN  SHALL carry the instr field of the IF/ID bundle.

Function
REQ-016 Block SHALL keep at most one memory request outstanding.
REQ-017 FSM SHALL have states REQ and WAIT: REQ goes to WAIT on handshake (imem_req_valid & imem_req_ready); WAIT goes to REQ on imem_rsp_valid.
REQ-018 In REQ, imem_req_valid SHALL be 1 iff the skid buffer is empty and redirect_valid is 0; in WAIT it SHALL be 0.
REQ-019 imem_req_addr SHALL equal pc_q and SHALL stay stable while imem_req_valid=1 and imem_req_ready=0.
REQ-020 On handshake, block SHALL latch pc_q as inflight_pc and set pc_q to pc_q+4, modulo 2^XLEN (32'hFFFF_FFFC wraps to 0).
REQ-021 An IF/ID entry SHALL be consumed in any cycle with if_id_valid=1 and stall_i=0.
REQ-022 A non-discarded response SHALL load {inflight_pc, imem_rsp_data} into the IF/ID register if that register is empty or being consumed, else into a one-entry skid buffer.
REQ-023 When an entry is consumed and the skid buffer is full, the skid contents SHALL move into the IF/ID register in the same edge and the skid SHALL empty.
REQ-024 When an entry is consumed with nothing to replace it, if_id_valid SHALL go to 0.
REQ-025 While stall_i=1 and no redirect occurs, the IF/ID outputs SHALL hold unchanged.
REQ-026 Minimum latency SHALL be: handshake at cycle N, response at N+1, if_id_valid=1 at N+2.
REQ-027 redirect_valid SHALL take priority over stall_i and all other events.
REQ-028 On redirect, block SHALL set pc_q to {redirect_pc[XLEN-1:2],2'b00}, clear if_id_valid, and empty the skid buffer.
REQ-029 If a redirect occurs in WAIT with no response that cycle, a discard flag SHALL be set; the next response SHALL be dropped, the flag SHALL clear, and the FSM SHALL return to REQ.
REQ-030 A response arriving in the same cycle as a redirect SHALL be dropped; no discard flag SHALL be set.
REQ-031 A further redirect while the discard flag is set SHALL only update pc_q, and only one response SHALL be dropped.
REQ-032 A redirect at cycle N in REQ SHALL produce a request for the target address at N+1.

Reset
REQ-033 While rst=1, block SHALL force state=REQ, pc_q=RESET_PC, discard=0, skid empty, if_id_valid=0, if_id_pc=0, if_id_instr=0, and imem_req_valid=0.
REQ-034 Reset asserted mid-request SHALL abandon any outstanding response; responses after reset release SHALL be treated as belonging to new requests only.
REQ-035 The first request after reset release SHALL be at address RESET_PC.

Verification
REQ-036 Reset release, ready=1, rsp one cycle after each request -> addrs 0x0,0x4,0x8; if_id_pc 0x0,0x4 with matching instr, no gaps beyond REQ-026 latency.
REQ-037 stall_i=1 for 3 cycles with IF/ID and skid full -> outputs hold, imem_req_valid=0, no entry lost or duplicated after stall release.
REQ-038 Redirect to 0x0000_0102 while in WAIT -> late response dropped, next request addr 0x0000_0100, if_id_valid=0 until its response.
REQ-039 Redirect coincident with response and stall_i=1 -> response dropped, IF/ID and skid cleared, request to target next cycle.
REQ-040 RESET_PC=32'hFFFF_FFFC -> request addrs 0xFFFF_FFFC then 0x0000_0000.
REQ-041 rst asserted while in WAIT, then response arrives after release -> that response not delivered as the RESET_PC instruction unless it follows a new handshake.

Source files
------------

// File: rtl/riscv_fetch_stage.sv
// Instruction fetch stage: one outstanding imem request, IF/ID register plus a
// one-entry skid buffer, redirect handling with single late-response discard.
module riscv_fetch_stage #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            stall_i,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_id_valid,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_instr
);

    typedef enum logic {S_REQ, S_WAIT} state_t;

    state_t          state;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] inflight_pc;
    logic            discard;
    logic            skid_valid;
    logic [XLEN-1:0] skid_pc;
    logic [XLEN-1:0] skid_instr;

    logic handshake;
    logic consume;
    logic rsp_take;
    logic deliver;

    // No new request while the skid holds an entry: that bounds storage to two.
    assign imem_req_valid = ~rst & (state == S_REQ) & ~skid_valid & ~redirect_valid;
    assign imem_req_addr  = pc_q;
    assign handshake      = imem_req_valid & imem_req_ready;
    assign consume        = if_id_valid & ~stall_i;
    assign rsp_take       = (state == S_WAIT) & imem_rsp_valid;
    assign deliver        = rsp_take & ~discard;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_REQ;
            pc_q        <= RESET_PC;
            inflight_pc <= '0;
            discard     <= 1'b0;
            skid_valid  <= 1'b0;
            skid_pc     <= '0;
            skid_instr  <= '0;
            if_id_valid <= 1'b0;
            if_id_pc    <= '0;
            if_id_instr <= '0;
        end else if (redirect_valid) begin
            pc_q        <= redirect_pc & ~XLEN'(3);
            if_id_valid <= 1'b0;
            skid_valid  <= 1'b0;
            // A coincident response is simply dropped; otherwise mark the pending one stale.
            if (rsp_take) begin
                state   <= S_REQ;
                discard <= 1'b0;
            end else if (state == S_WAIT) begin
                discard <= 1'b1;
            end
        end else begin
            if (handshake) begin
                state       <= S_WAIT;
                inflight_pc <= pc_q;
                pc_q        <= pc_q + XLEN'(4);
            end
            if (rsp_take) begin
                state   <= S_REQ;
                discard <= 1'b0;
            end
            if (consume) begin
                if (skid_valid) begin
                    if_id_pc    <= skid_pc;
                    if_id_instr <= skid_instr;
                    skid_valid  <= deliver;
                    if (deliver) begin
                        skid_pc    <= inflight_pc;
                        skid_instr <= imem_rsp_data;
                    end
                end else if (deliver) begin
                    if_id_pc    <= inflight_pc;
                    if_id_instr <= imem_rsp_data;
                end else begin
                    if_id_valid <= 1'b0;
                end
            end else if (deliver) begin
                if (!if_id_valid) begin
                    if_id_valid <= 1'b1;
                    if_id_pc    <= inflight_pc;
                    if_id_instr <= imem_rsp_data;
                end else begin
                    skid_valid <= 1'b1;
                    skid_pc    <= inflight_pc;
                    skid_instr <= imem_rsp_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_riscv_fetch_stage.sv
// Bench for riscv_fetch_stage: directed vector table, reset/wrap sequences and a
// randomized run checked against a queue-based model of the delivered stream.
module tb_riscv_fetch_stage;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        req_valid, req_ready, rsp_valid, stall, rd_valid;
    logic [31:0] req_addr, rsp_data, rd_pc;
    logic        iv;
    logic [31:0] ipc, iins;

    logic        req_valid_b, req_ready_b, rsp_valid_b, iv_b;
    logic [31:0] req_addr_b, rsp_data_b, ipc_b, iins_b;

    riscv_fetch_stage #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_req_addr(req_addr),
        .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
        .stall_i(stall), .redirect_valid(rd_valid), .redirect_pc(rd_pc),
        .if_id_valid(iv), .if_id_pc(ipc), .if_id_instr(iins)
    );

    riscv_fetch_stage #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst),
        .imem_req_valid(req_valid_b), .imem_req_ready(req_ready_b), .imem_req_addr(req_addr_b),
        .imem_rsp_valid(rsp_valid_b), .imem_rsp_data(rsp_data_b),
        .stall_i(1'b0), .redirect_valid(1'b0), .redirect_pc(32'h0),
        .if_id_valid(iv_b), .if_id_pc(ipc_b), .if_id_instr(iins_b)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
    endtask

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_ready = 0; rsp_valid = 0; rsp_data = 0; stall = 0; rd_valid = 0; rd_pc = 0;
    endtask

    typedef struct {
        logic        rdy, rv;
        logic [31:0] rd;
        logic        st, dv;
        logic [31:0] dpc;
        logic        erv;
        logic [31:0] era;
        logic        eiv;
        logic [31:0] epc, eins;
    } vec_t;

    function automatic vec_t mk(logic rdy, logic rv, logic [31:0] rd, logic st, logic dv,
                                logic [31:0] dpc, logic erv, logic [31:0] era,
                                logic eiv, logic [31:0] epc, logic [31:0] eins);
        vec_t v;
        v.rdy = rdy; v.rv = rv; v.rd = rd; v.st = st; v.dv = dv; v.dpc = dpc;
        v.erv = erv; v.era = era; v.eiv = eiv; v.epc = epc; v.eins = eins;
        return v;
    endfunction

    localparam logic [31:0] D0 = 32'hC0DE_0000, D1 = 32'hC0DE_0001, D2 = 32'hC0DE_0002;
    localparam logic [31:0] D3 = 32'hC0DE_0003, D4 = 32'hC0DE_0004, D5 = 32'hC0DE_0005;
    localparam logic [31:0] D6 = 32'hC0DE_0006, D7 = 32'hC0DE_0007, DX = 32'hBAD0_0001;

    vec_t tbl[29];

    // random-phase model state
    logic [31:0] q_pc[$];
    logic [31:0] q_ins[$];
    logic [31:0] nreq, out_addr, tgt;
    logic        outstanding, stale, exp_rv, rsp_now, hs;
    int          cnt, ndel;

    initial begin
        //           rdy rv rd  st dv dpc           erv era           eiv epc           eins
        tbl[0]  = mk(1, 0, 0,  0, 0, 0,            1, 32'h0,         0, 0,            0);
        tbl[1]  = mk(0, 1, D0, 0, 0, 0,            0, 0,             0, 0,            0);
        tbl[2]  = mk(1, 0, 0,  0, 0, 0,            1, 32'h4,         1, 32'h0,        D0);
        tbl[3]  = mk(0, 1, D1, 0, 0, 0,            0, 0,             0, 0,            0);
        tbl[4]  = mk(1, 0, 0,  1, 0, 0,            1, 32'h8,         1, 32'h4,        D1);
        tbl[5]  = mk(0, 1, D2, 1, 0, 0,            0, 0,             1, 32'h4,        D1);
        tbl[6]  = mk(1, 0, 0,  1, 0, 0,            0, 0,             1, 32'h4,        D1);
        tbl[7]  = mk(1, 0, 0,  1, 0, 0,            0, 0,             1, 32'h4,        D1);
        tbl[8]  = mk(1, 0, 0,  1, 0, 0,            0, 0,             1, 32'h4,        D1);
        tbl[9]  = mk(1, 0, 0,  0, 0, 0,            0, 0,             1, 32'h4,        D1);
        tbl[10] = mk(1, 0, 0,  0, 0, 0,            1, 32'hC,         1, 32'h8,        D2);
        tbl[11] = mk(0, 0, 0,  0, 1, 32'h102,      0, 0,             0, 0,            0);
        tbl[12] = mk(0, 1, DX, 0, 0, 0,            0, 0,             0, 0,            0);
        tbl[13] = mk(1, 0, 0,  0, 0, 0,            1, 32'h100,       0, 0,            0);
        tbl[14] = mk(0, 1, D3, 0, 0, 0,            0, 0,             0, 0,            0);
        tbl[15] = mk(1, 0, 0,  1, 0, 0,            1, 32'h104,       1, 32'h100,      D3);
        tbl[16] = mk(0, 1, D4, 1, 1, 32'h200,      0, 0,             1, 32'h100,      D3);
        tbl[17] = mk(1, 0, 0,  0, 0, 0,            1, 32'h200,       0, 0,            0);
        tbl[18] = mk(0, 1, D5, 0, 0, 0,            0, 0,             0, 0,            0);
        tbl[19] = mk(0, 0, 0,  0, 0, 0,            1, 32'h204,       1, 32'h200,      D5);
        tbl[20] = mk(0, 0, 0,  0, 0, 0,            1, 32'h204,       0, 0,            0);
        tbl[21] = mk(1, 0, 0,  0, 1, 32'h300,      0, 0,             0, 0,            0);
        tbl[22] = mk(1, 0, 0,  0, 0, 0,            1, 32'h300,       0, 0,            0);
        tbl[23] = mk(0, 0, 0,  0, 1, 32'h400,      0, 0,             0, 0,            0);
        tbl[24] = mk(0, 0, 0,  0, 1, 32'h502,      0, 0,             0, 0,            0);
        tbl[25] = mk(0, 1, D6, 0, 0, 0,            0, 0,             0, 0,            0);
        tbl[26] = mk(1, 0, 0,  0, 0, 0,            1, 32'h500,       0, 0,            0);
        tbl[27] = mk(0, 1, D7, 0, 0, 0,            0, 0,             0, 0,            0);
        tbl[28] = mk(0, 0, 0,  1, 0, 0,            1, 32'h504,       1, 32'h500,      D7);

        idle();
        req_ready_b = 0; rsp_valid_b = 0; rsp_data_b = 0;
        rst = 1;
        tick(); tick();
        chk("rst_req_valid", 0, {31'b0, req_valid}, 32'h0);
        chk("rst_if_id_valid", 0, {31'b0, iv}, 32'h0);
        rst = 0;

        // wrap-around from the top of the address space
        req_ready_b = 1; #2;
        chk("wrap_req_valid", 0, {31'b0, req_valid_b}, 32'h1);
        chk("wrap_addr", 0, req_addr_b, 32'hFFFF_FFFC);
        tick();
        req_ready_b = 0; rsp_valid_b = 1; rsp_data_b = mem(32'hFFFF_FFFC); #2;
        chk("wrap_req_valid", 1, {31'b0, req_valid_b}, 32'h0);
        tick();
        rsp_valid_b = 0; req_ready_b = 1; #2;
        chk("wrap_addr", 1, req_addr_b, 32'h0000_0000);
        chk("wrap_if_id_valid", 0, {31'b0, iv_b}, 32'h1);
        chk("wrap_if_id_pc", 0, ipc_b, 32'hFFFF_FFFC);
        chk("wrap_if_id_instr", 0, iins_b, mem(32'hFFFF_FFFC));
        tick();
        req_ready_b = 0;

        for (int i = 0; i < 29; i++) begin
            req_ready = tbl[i].rdy; rsp_valid = tbl[i].rv; rsp_data = tbl[i].rd;
            stall = tbl[i].st; rd_valid = tbl[i].dv; rd_pc = tbl[i].dpc;
            #2;
            chk("tbl_req_valid", i, {31'b0, req_valid}, {31'b0, tbl[i].erv});
            if (tbl[i].erv) chk("tbl_req_addr", i, req_addr, tbl[i].era);
            chk("tbl_if_id_valid", i, {31'b0, iv}, {31'b0, tbl[i].eiv});
            if (tbl[i].eiv) begin
                chk("tbl_if_id_pc", i, ipc, tbl[i].epc);
                chk("tbl_if_id_instr", i, iins, tbl[i].eins);
            end
            tick();
        end

        // reset while a request is outstanding; the late response must not surface
        idle(); req_ready = 1; stall = 1; #2;
        chk("mid_req_valid", 0, {31'b0, req_valid}, 32'h1);
        tick();
        idle(); rst = 1; #2;
        chk("rst2_req_valid", 0, {31'b0, req_valid}, 32'h0);
        chk("rst2_if_id_valid", 0, {31'b0, iv}, 32'h0);
        chk("rst2_if_id_pc", 0, ipc, 32'h0);
        chk("rst2_if_id_instr", 0, iins, 32'h0);
        tick();
        rst = 0;
        rsp_valid = 1; rsp_data = 32'hDEAD_BEEF; #2;
        chk("post_rst_req_valid", 0, {31'b0, req_valid}, 32'h1);
        chk("post_rst_addr", 0, req_addr, 32'h0);
        tick();
        rsp_valid = 0; #2;
        chk("stale_rsp_ignored", 0, {31'b0, iv}, 32'h0);
        req_ready = 1; #2;
        chk("post_rst_addr", 1, req_addr, 32'h0);
        tick();
        req_ready = 0; rsp_valid = 1; rsp_data = mem(32'h0);
        tick();
        rsp_valid = 0; #2;
        chk("post_rst_if_id_valid", 0, {31'b0, iv}, 32'h1);
        chk("post_rst_if_id_pc", 0, ipc, 32'h0);
        chk("post_rst_if_id_instr", 0, iins, mem(32'h0));
        tick();

        // randomized run against the delivered-stream model
        idle(); rst = 1; tick(); rst = 0;
        q_pc.delete(); q_ins.delete();
        nreq = 0; outstanding = 0; stale = 0; cnt = 0; ndel = 0; out_addr = 0;
        for (int c = 0; c < 3000; c++) begin
            req_ready = ($urandom_range(0, 3) != 0);
            stall     = ($urandom_range(0, 2) == 0);
            rd_valid  = ($urandom_range(0, 15) == 0);
            rd_pc     = $urandom();
            rsp_now   = outstanding && (cnt == 0);
            rsp_valid = rsp_now;
            rsp_data  = rsp_now ? mem(out_addr) : $urandom();
            #2;
            exp_rv = !outstanding && (q_pc.size() < 2) && !rd_valid;
            chk("rnd_req_valid", c, {31'b0, req_valid}, {31'b0, exp_rv});
            if (exp_rv) chk("rnd_req_addr", c, req_addr, nreq);
            chk("rnd_if_id_valid", c, {31'b0, iv}, {31'b0, (q_pc.size() > 0)});
            if (q_pc.size() > 0) begin
                chk("rnd_if_id_pc", c, ipc, q_pc[0]);
                chk("rnd_if_id_instr", c, iins, q_ins[0]);
            end
            hs = exp_rv && req_ready;
            if (rd_valid) begin
                q_pc.delete(); q_ins.delete();
                tgt = rd_pc;
                nreq = {tgt[31:2], 2'b00};
                if (rsp_now) begin
                    outstanding = 0; stale = 0;
                end else if (outstanding) begin
                    stale = 1;
                end
            end else begin
                if (q_pc.size() > 0 && !stall) begin
                    void'(q_pc.pop_front()); void'(q_ins.pop_front()); ndel++;
                end
                if (rsp_now) begin
                    outstanding = 0;
                    if (!stale) begin q_pc.push_back(out_addr); q_ins.push_back(mem(out_addr)); end
                    stale = 0;
                end
                if (hs) begin
                    outstanding = 1; out_addr = nreq; nreq = nreq + 32'd4;
                    cnt = $urandom_range(0, 2);
                end
            end
            if (outstanding && !rsp_now && !hs && cnt > 0) cnt--;
            tick();
        end
        chk("rnd_delivered_enough", 0, {31'b0, (ndel > 100)}, 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
